unaligned_stream_reader: RTL and testbench

Sequential read engine that streams an arbitrary run of 32-bit words starting at any byte address out of a word-organised synchronous SSRAM. It handles unaligned starts by reading only aligned words and realigning them with a two-word window. It sits on the aligned port of the scratchpad, after the DMA/custom-instruction path, and feeds a valid/ready consumer.

---
 rtl/unaligned_stream_reader.sv | 113 +++++++++++
 tb/tb_unaligned_stream_reader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/unaligned_stream_reader.sv
// Streams 32-bit words from any byte address out of a word-organised synchronous RAM,
// realigning unaligned starts through a two-word (prev, ramData) window.
module unaligned_stream_reader #(
    parameter int BITWIDTH      = 32,
    parameter int NR_OF_ENTRIES = 640,
    localparam int AW           = $clog2(NR_OF_ENTRIES)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [AW+1:0]       byte_address_i,
    input  logic [AW:0]         word_count_i,
    output logic [AW-1:0]       ram_address_o,
    input  logic [BITWIDTH-1:0] ram_data_i,
    output logic [BITWIDTH-1:0] stream_data_o,
    output logic                stream_valid_o,
    input  logic                stream_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    // state  | meaning
    // IDLE   | waiting for start
    // PRIME0 | present first word address
    // PRIME1 | capture first word into prev, present second address
    // STREAM | emit realigned words, one per transfer
    // DONE   | single-cycle completion pulse
    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [BITWIDTH-1:0]   prev_q, prev_d;
    logic [AW-1:0]         cur_addr_q, cur_addr_d;
    logic [AW:0]           remaining_q, remaining_d;
    logic [1:0]            offset_q, offset_d;
    logic [2*BITWIDTH-1:0] window;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(NR_OF_ENTRIES - 1)) ? '0 : a + 1'b1;
    endfunction

    assign window = {prev_q, ram_data_i} << {offset_q, 3'b000};

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        cur_addr_d     = cur_addr_q;
        remaining_d    = remaining_q;
        offset_d       = offset_q;
        ram_address_o  = '0;
        stream_data_o  = '0;
        stream_valid_o = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    offset_d    = byte_address_i[1:0];
                    cur_addr_d  = byte_address_i[AW+1:2];
                    remaining_d = word_count_i;
                    state_d     = (word_count_i == '0) ? DONE : PRIME0;
                end
            end
            PRIME0: begin
                busy_o        = 1'b1;
                ram_address_o = cur_addr_q;
                cur_addr_d    = addr_inc(cur_addr_q);
                state_d       = PRIME1;
            end
            PRIME1: begin
                busy_o        = 1'b1;
                ram_address_o = cur_addr_q;
                prev_d        = ram_data_i;
                state_d       = STREAM;
            end
            STREAM: begin
                busy_o         = 1'b1;
                stream_valid_o = 1'b1;
                stream_data_o  = window[2*BITWIDTH-1:BITWIDTH];
                ram_address_o  = cur_addr_q;
                // Advancing the address in the transfer cycle keeps one word per cycle.
                if (stream_ready_i) begin
                    prev_d        = ram_data_i;
                    remaining_d   = remaining_q - 1'b1;
                    cur_addr_d    = addr_inc(cur_addr_q);
                    ram_address_o = addr_inc(cur_addr_q);
                    if (remaining_q == (AW+1)'(1)) state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            offset_q    <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
        end
    end

endmodule

// File: tb/tb_unaligned_stream_reader.sv
// Bench for unaligned_stream_reader: directed scenarios plus random transfers checked
// against a window-shift reference computed straight from the RAM image.
module tb_unaligned_stream_reader;

    localparam int N  = 640;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW+1:0] byte_address;
    logic [AW:0]   word_count;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic [31:0]   data;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;

    logic [31:0]   mem [N];
    int            n_tests = 0;
    int            n_fail  = 0;

    unaligned_stream_reader #(.BITWIDTH(32), .NR_OF_ENTRIES(N)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .byte_address_i (byte_address),
        .word_count_i   (word_count),
        .ram_address_o  (ram_addr),
        .ram_data_i     (ram_data),
        .stream_data_o  (data),
        .stream_valid_o (valid),
        .stream_ready_i (ready),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        ram_data <= (int'(ram_addr) < N) ? mem[ram_addr] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output word k = top 32 bits of {W[w+k], W[w+k+1]} shifted left by 8*offset.
    function automatic logic [31:0] ref_word(input int w, input int o, input int k);
        logic [63:0] win;
        win = {mem[(w + k) % N], mem[(w + k + 1) % N]};
        win = win << (8 * o);
        return win[63:32];
    endfunction

    task automatic run(input int ba, input int wc, input int st_lo, input int st_hi,
                       input int pct, input bit poke);
        int w, o, k;
        bit fin, rdy;
        w = ba / 4; o = ba % 4; k = 0; fin = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; byte_address = (AW+2)'(ba); word_count = (AW+1)'(wc); ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; byte_address = (AW+2)'($urandom); word_count = (AW+1)'($urandom);
        if (wc == 0) begin
            @(negedge clk);
            chk("zero_done", {busy, valid, done}, 3'b001);
        end else begin
            for (int cyc = 1; cyc < 4 * wc + 40 && !fin; cyc++) begin
                rdy   = !(cyc >= st_lo && cyc <= st_hi) && ($urandom_range(99) >= pct);
                ready = rdy;
                if (poke) begin
                    start        = (cyc == 4);
                    byte_address = (AW+2)'($urandom);
                end
                @(negedge clk);
                if (k == wc) begin
                    chk("done_pulse", {busy, valid, done}, 3'b001);
                    fin = 1'b1;
                end else if (cyc == 1) begin
                    chk("prime0_flags", {busy, valid, done}, 3'b100);
                    chk("prime0_addr", ram_addr, (w % N));
                end else if (cyc == 2) begin
                    chk("prime1_flags", {busy, valid, done}, 3'b100);
                    chk("prime1_addr", ram_addr, ((w + 1) % N));
                end else begin
                    chk("stream_flags", {busy, valid, done}, 3'b110);
                    chk("stream_data", data, ref_word(w, o, k));
                    chk("stream_addr", ram_addr, rdy ? ((w + k + 2) % N) : ((w + k + 1) % N));
                    if (rdy) k++;
                end
                if (!fin) begin
                    @(posedge clk); #1;
                end
            end
            start = 1'b0;
            if (!fin) chk("timeout", 0, 1);
        end
        // A start during the done cycle must be ignored.
        start = 1'b1; byte_address = '0; word_count = (AW+1)'(1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {busy, valid, done}, 3'b000);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; byte_address = '0; word_count = '0; ready = 1'b0;
        for (int i = 0; i < N; i++)
            mem[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, valid, done, ram_addr, data}, '0);
        rst_n = 1'b1;

        run(8, 2, 0, 0, 0, 1'b0);
        run(5, 3, 0, 0, 0, 1'b0);
        run(6, 2, 3, 5, 0, 1'b0);
        run(2558, 2, 0, 0, 0, 1'b0);
        run(12, 0, 0, 0, 0, 1'b0);
        run(21, 5, 0, 0, 0, 1'b1);

        // Reset in cycle 4 of a wordCount=4 transfer.
        @(posedge clk); #1;
        start = 1'b1; byte_address = (AW+2)'(40); word_count = (AW+1)'(4); ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_valid", {busy, valid}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy, valid, done, ram_addr, data}, '0);
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_done", {busy, done}, 2'b00);
        end
        rst_n = 1'b1;
        run(0, 1, 0, 0, 0, 1'b0);

        for (int i = 0; i < N; i++) mem[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            int wc;
            wc = $urandom_range(12);
            run($urandom_range(4 * N - 1), wc, 0, 0, 30, (wc >= 3) && ($urandom_range(1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
